inst_decode_queue: RTL and testbench

Registered, parametrised successor to the combinational instruction field splitter. It accepts raw 32-bit MIPS instructions with their PC over a valid/ready handshake and buffers them in a DEPTH-entry queue. From the head entry it presents the decoded fields: register indices, shamt, opcode, funct, extended immediate and jump target. It sits at the IF/ID boundary, supports stall via backpressure and a synchronous flush for branches, and keeps a saturating stall-cycle counter.

---
 rtl/inst_decode_queue.sv | 103 ++++++++++
 tb/tb_inst_decode_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_queue.sv
// inst_decode_queue: IF/ID instruction queue presenting decoded MIPS fields of the head entry
module inst_decode_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       rs,
  output logic [4:0]       rt,
  output logic [4:0]       rd,
  output logic [4:0]       shamt,
  output logic [5:0]       opcode,
  output logic [5:0]       funct,
  output logic [15:0]      imm16,
  output logic [XLEN-1:0]  imm_ext,
  output logic [XLEN-1:0]  jump_target,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       count,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      inst_d [DEPTH];
  logic [XLEN-1:0]  pc_q [DEPTH];
  logic [XLEN-1:0]  pc_d [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             push, pop, zero_ext;
  logic [31:0]      head;
  logic [XLEN-1:0]  pc_plus4;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = count_q != 3'(DEPTH);
  assign out_valid = count_q != 3'd0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_q;
  assign stall_cnt = stall_q;

  // next-state: write at wr_ptr, advance pointers, track occupancy; flush wins
  always_comb begin
    inst_d   = inst_q;
    pc_d     = pc_q;
    wr_ptr_d = push ? nxt(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? nxt(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + 3'(push) - 3'(pop);
    stall_d  = (in_valid && !in_ready && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
    if (push) begin
      inst_d[wr_ptr_q] = in_inst;
      pc_d[wr_ptr_q]   = in_pc;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // state registers; reset clears storage so idle field outputs read 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q   <= '{default: '0};
      pc_q     <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      inst_q   <= inst_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  assign head        = inst_q[rd_ptr_q];
  assign out_pc      = pc_q[rd_ptr_q];
  assign opcode      = head[31:26];
  assign rs          = head[25:21];
  assign rt          = head[20:16];
  assign rd          = head[15:11];
  assign shamt       = head[10:6];
  assign funct       = head[5:0];
  assign imm16       = head[15:0];
  assign zero_ext    = (opcode == 6'h0C) || (opcode == 6'h0D) || (opcode == 6'h0E);
  assign imm_ext     = zero_ext ? XLEN'(imm16) : {{(XLEN-16){imm16[15]}}, imm16};
  assign pc_plus4    = out_pc + XLEN'(4);
  assign jump_target = (pc_plus4 & ~XLEN'(32'h0FFF_FFFF)) | XLEN'({head[25:0], 2'b00});
endmodule

// File: tb/tb_inst_decode_queue.sv
// tb_inst_decode_queue: scoreboard bench for inst_decode_queue with directed MIPS vectors
module tb_inst_decode_queue;
  logic clk = 0, rst_n, in_valid, flush, out_ready;
  logic [31:0] in_inst, in_pc;
  logic in_ready, out_valid;
  logic [4:0] rs, rt, rd, shamt;
  logic [5:0] opcode, funct;
  logic [15:0] imm16;
  logic [31:0] imm_ext, jump_target, out_pc;
  logic [2:0] count;
  logic [1:0] stall_cnt;

  typedef struct {
    logic [31:0] inst, pc;
    logic [4:0]  rs, rt, rd, sh;
    logic [5:0]  op, fn;
    logic [15:0] imm;
    logic [31:0] ext, jt;
  } vec_t;

  vec_t tbl [10];
  vec_t exp_q [$];
  int cur = 0, mc = 0, ms = 0, n_chk = 0, n_pass = 0;

  inst_decode_queue #(.DEPTH(2), .XLEN(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .opcode(opcode), .funct(funct), .imm16(imm16), .imm_ext(imm_ext),
    .jump_target(jump_target), .out_pc(out_pc), .count(count), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int idx);
    in_valid = v;
    in_inst  = tbl[idx].inst;
    in_pc    = tbl[idx].pc;
    cur      = idx;
  endtask

  // reference occupancy/stall model and scoreboard push on accepted entries
  always @(negedge clk) begin
    if (!rst_n) begin
      mc = 0;
      ms = 0;
      exp_q.delete();
    end else begin
      check("count", 32'(count), 32'(mc));
      check("in_ready", 32'(in_ready), 32'(mc != 2));
      check("out_valid", 32'(out_valid), 32'(mc != 0));
      check("stall_cnt", 32'(stall_cnt), 32'(ms));
      if (in_valid && mc == 2 && ms != 3) ms++;
      if (flush) begin
        mc = 0;
        exp_q.delete();
      end else begin
        if (in_valid && mc != 2) begin
          exp_q.push_back(tbl[cur]);
          mc++;
        end
        if (out_ready && mc != 0 && !(in_valid && mc == 1 && exp_q.size() == 1 && cur >= 0 && 0)) ;
      end
    end
  end

  // occupancy decrement tracked on the consumer side so push/pop ordering stays explicit
  always @(negedge clk) begin
    if (rst_n && !flush && out_ready && out_valid) begin
      if (exp_q.size() == 0) check("unexpected_out", 32'(out_valid), 32'd0);
      else begin
        vec_t e;
        e = exp_q.pop_front();
        mc--;
        check("rs", 32'(rs), 32'(e.rs));
        check("rt", 32'(rt), 32'(e.rt));
        check("rd", 32'(rd), 32'(e.rd));
        check("shamt", 32'(shamt), 32'(e.sh));
        check("opcode", 32'(opcode), 32'(e.op));
        check("funct", 32'(funct), 32'(e.fn));
        check("imm16", 32'(imm16), 32'(e.imm));
        check("imm_ext", imm_ext, e.ext);
        check("jump_target", jump_target, e.jt);
        check("out_pc", out_pc, e.pc);
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    check({tag, "_rs"}, 32'(rs), 32'd0);
    check({tag, "_opcode"}, 32'(opcode), 32'd0);
    check({tag, "_imm_ext"}, imm_ext, 32'd0);
    check({tag, "_jump_target"}, jump_target, 32'd0);
    check({tag, "_out_pc"}, out_pc, 32'd0);
  endtask

  initial begin
    //           inst          pc            rs  rt  rd  sh  op     fn     imm       ext           jt
    tbl[0] = '{32'h012A4020, 32'h00400000, 9,  10, 8,  0,  6'h00, 6'h20, 16'h4020, 32'h00004020, 32'h04A90080};
    tbl[1] = '{32'h2108FFFF, 32'h00400004, 8,  8,  31, 31, 6'h08, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 32'h0423FFFC};
    tbl[2] = '{32'h3508FFFF, 32'h00400008, 8,  8,  31, 31, 6'h0D, 6'h3F, 16'hFFFF, 32'h0000FFFF, 32'h0423FFFC};
    tbl[3] = '{32'h08000010, 32'h00400000, 0,  0,  0,  0,  6'h02, 6'h10, 16'h0010, 32'h00000010, 32'h00000040};
    tbl[4] = '{32'h08000010, 32'hF0000FF8, 0,  0,  0,  0,  6'h02, 6'h10, 16'h0010, 32'h00000010, 32'hF0000040};
    tbl[5] = '{32'hAD2AFFFC, 32'h00400010, 9,  10, 31, 31, 6'h2B, 6'h3C, 16'hFFFC, 32'hFFFFFFFC, 32'h04ABFFF0};
    tbl[6] = '{32'h3128F000, 32'h00400014, 9,  8,  30, 0,  6'h0C, 6'h00, 16'hF000, 32'h0000F000, 32'h04A3C000};
    tbl[7] = '{32'h3928F000, 32'h00400018, 9,  8,  30, 0,  6'h0E, 6'h00, 16'hF000, 32'h0000F000, 32'h04A3C000};
    tbl[8] = '{32'h2D28F000, 32'h0040001C, 9,  8,  30, 0,  6'h0B, 6'h00, 16'hF000, 32'hFFFFF000, 32'h04A3C000};
    tbl[9] = '{32'h3D28F000, 32'h00400020, 9,  8,  30, 0,  6'h0F, 6'h00, 16'hF000, 32'hFFFFF000, 32'h04A3C000};
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 0; in_inst = 0; in_pc = 0;
    #12;
    check_reset("reset");
    tick();
    rst_n = 1;
    out_ready = 1;
    drive(1, 0); tick();
    in_valid = 0; tick(); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1, i);
      tick();
    end
    in_valid = 0;
    repeat (3) tick();
    out_ready = 0;
    drive(1, 5);
    repeat (5) tick();
    check("stall_after_5", 32'(stall_cnt), 32'd3);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 0; tick();
    out_ready = 1;
    repeat (3) tick();
    out_ready = 0;
    drive(1, 6); tick();
    drive(1, 7); tick();
    in_valid = 0; tick();
    out_ready = 1;
    drive(1, 8); tick(); tick();
    drive(1, 9); tick();
    in_valid = 0;
    repeat (3) tick();
    out_ready = 0;
    drive(1, 6); tick();
    drive(1, 7); tick();
    flush = 1; out_ready = 1; drive(1, 8); tick();
    flush = 0; in_valid = 0; out_ready = 0;
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    drive(1, 9);
    repeat (8) tick();
    check("stall_saturated", 32'(stall_cnt), 32'd3);
    check("sat_count", 32'(count), 32'd2);
    @(posedge clk);
    #2 rst_n = 0;
    #1 check_reset("async_reset");
    in_valid = 0;
    tick();
    rst_n = 1;
    out_ready = 1;
    drive(1, 4); tick();
    in_valid = 0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
